snr_stats_sequencer: RTL and testbench

Controller that computes the mean and unbiased variance of a stored PPG sample block for the SNR path. It makes two sequential passes over the single read port of the sample memory: a sum pass, then a squared-deviation pass. Both divisions go to one externally shared multi-cycle divider, which this block requests over a ready/start/done handshake. It sits between the sample RAM and the SNR ratio stage, and replaces free-running per-statistic readers with a single scheduled reader.

---
 rtl/snr_stats_pkg.sv | 21 ++
 rtl/snr_stats_sequencer_reader.sv | 48 ++++
 rtl/snr_stats_sequencer.sv | 152 +++++++++++++++
 tb/tb_snr_stats_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snr_stats_pkg.sv
// rtl/snr_stats_pkg.sv - shared widths and FSM encoding for the SNR statistics sequencer
package snr_stats_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;
  localparam int SUM_W  = DATA_W + ADDR_W;
  localparam int SQ_W   = 2 * DATA_W + ADDR_W;
  localparam int DEV_W  = DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM_RD,
    S_MEAN_REQ,
    S_MEAN_WAIT,
    S_SQ_RD,
    S_VAR_REQ,
    S_VAR_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/snr_stats_sequencer_reader.sv
// rtl/snr_stats_sequencer_reader.sv - one linear pass over the sample memory with a delayed data valid
module sample_pass_reader
  import snr_stats_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int N_SAMPLES  = 5968
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  data_valid,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_SAMPLES - 1);

  logic active;
  logic at_end;

  assign at_end    = (mem_addr == LAST_ADDR);
  assign mem_rd_en = active;

  // Walk addresses 0..N-1 after go; valid/last trail the strobe by the memory latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      active     <= 1'b0;
      mem_addr   <= '0;
      data_valid <= 1'b0;
      last       <= 1'b0;
    end else begin
      data_valid <= active;
      last       <= active && at_end;
      if (go) begin
        active   <= 1'b1;
        mem_addr <= '0;
      end else if (active) begin
        if (at_end) begin
          active <= 1'b0;
        end else begin
          mem_addr <= mem_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/snr_stats_sequencer.sv
// rtl/snr_stats_sequencer.sv - two-pass mean/variance controller sharing one read port and one divider
module snr_stats_sequencer
  import snr_stats_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int N_SAMPLES  = 5968,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int NUM_WIDTH  = SQ_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    div_ready,
  output logic                    div_start,
  output logic [NUM_WIDTH-1:0]    div_num,
  output logic [ADDR_WIDTH-1:0]   div_den,
  input  logic                    div_done,
  input  logic [NUM_WIDTH-1:0]    div_quot,
  output logic [DATA_WIDTH-1:0]   mean,
  output logic [2*DATA_WIDTH-1:0] variance
);

  // Package widths track any override of the data/address widths.
  localparam int SUM_BITS = SUM_W + (DATA_WIDTH - DATA_W) + (ADDR_WIDTH - ADDR_W);
  localparam int DEV_BITS = DEV_W + (DATA_WIDTH - DATA_W);

  state_t                    state;
  logic                      go;
  logic                      rd_valid;
  logic                      rd_last;
  logic [SUM_BITS-1:0]       sum;
  logic [NUM_WIDTH-1:0]      sqsum;
  logic [DATA_WIDTH-1:0]     mean_q;
  logic [2*DATA_WIDTH-1:0]   var_q;
  logic signed [DEV_BITS-1:0]   dev;
  logic signed [2*DEV_BITS-1:0] dev_ext;
  logic signed [2*DEV_BITS-1:0] dev_sq;
  logic                      unused_quot_hi;

  assign unused_quot_hi = ^div_quot[NUM_WIDTH-1:2*DATA_WIDTH];

  assign dev     = $signed({1'b0, mem_data}) - $signed({1'b0, mean_q});
  assign dev_ext = (2*DEV_BITS)'(dev);
  assign dev_sq  = dev_ext * dev_ext;

  // The reader restarts for the sum pass and again once the mean is back from the divider.
  assign go = ((state == S_IDLE) && start) || ((state == S_MEAN_WAIT) && div_done);

  sample_pass_reader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_SAMPLES  (N_SAMPLES)
  ) u_reader (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .data_valid (rd_valid),
    .last       (rd_last)
  );

  assign div_start = ((state == S_MEAN_REQ) || (state == S_VAR_REQ)) && div_ready;

  // Operands are steered from the accumulators, which stay frozen until the quotient returns.
  always_comb begin
    div_num = '0;
    div_den = '0;
    case (state)
      S_MEAN_REQ, S_MEAN_WAIT: begin
        div_num = NUM_WIDTH'(sum);
        div_den = ADDR_WIDTH'(N_SAMPLES);
      end
      S_VAR_REQ, S_VAR_WAIT: begin
        div_num = sqsum;
        div_den = ADDR_WIDTH'(N_SAMPLES - 1);
      end
      default: ;
    endcase
  end

  // Sequencer: sum pass, mean divide, squared-deviation pass, variance divide, publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      sum      <= '0;
      sqsum    <= '0;
      mean_q   <= '0;
      var_q    <= '0;
      mean     <= '0;
      variance <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SUM_RD;
            busy  <= 1'b1;
            sum   <= '0;
            sqsum <= '0;
            var_q <= '0;
          end
        end
        S_SUM_RD: begin
          if (rd_valid) begin
            sum <= sum + SUM_BITS'(mem_data);
            if (rd_last) state <= S_MEAN_REQ;
          end
        end
        S_MEAN_REQ: begin
          if (div_ready) state <= S_MEAN_WAIT;
        end
        S_MEAN_WAIT: begin
          if (div_done) begin
            mean_q <= div_quot[DATA_WIDTH-1:0];
            state  <= S_SQ_RD;
          end
        end
        S_SQ_RD: begin
          if (rd_valid) begin
            sqsum <= sqsum + NUM_WIDTH'($unsigned(dev_sq));
            if (rd_last) state <= (N_SAMPLES == 1) ? S_DONE : S_VAR_REQ;
          end
        end
        S_VAR_REQ: begin
          if (div_ready) state <= S_VAR_WAIT;
        end
        S_VAR_WAIT: begin
          if (div_done) begin
            var_q <= div_quot[2*DATA_WIDTH-1:0];
            state <= S_DONE;
          end
        end
        S_DONE: begin
          mean     <= mean_q;
          variance <= var_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snr_stats_sequencer.sv
// tb/tb_snr_stats_sequencer.sv - randomized self-checking bench for snr_stats_sequencer
module tb_snr_stats_sequencer;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int NW = 45;
  localparam int D  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference statistics straight from the definitions of mean and unbiased variance.
  function automatic void stats(input longint xs[$], output longint m, output longint v);
    longint s = 0;
    longint ss = 0;
    foreach (xs[i]) s += xs[i];
    m = s / xs.size();
    foreach (xs[i]) ss += (xs[i] - m) * (xs[i] - m);
    v = (xs.size() == 1) ? 0 : ss / (xs.size() - 1);
  endfunction

  // ---------------- instance with N_SAMPLES = 4 ----------------
  logic          start4 = 1'b0, busy4, done4, rd4, ready4 = 1'b1, dstart4, ddone4, spur4 = 1'b0;
  logic [AW-1:0] addr4, den4;
  logic [DW-1:0] data4, mean4;
  logic [NW-1:0] num4, quot4;
  logic [2*DW-1:0] var4;
  logic [DW-1:0] mem4 [0:3];
  int            reads4 = 0, dstarts4 = 0, cnt4 = 0;
  logic          pend4 = 1'b0, mdone4 = 1'b0;
  logic [NW-1:0] cap_num4;
  logic [AW-1:0] cap_den4;

  snr_stats_sequencer #(.DATA_WIDTH(DW), .N_SAMPLES(4), .ADDR_WIDTH(AW), .NUM_WIDTH(NW)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
    .mem_rd_en(rd4), .mem_addr(addr4), .mem_data(data4),
    .div_ready(ready4), .div_start(dstart4), .div_num(num4), .div_den(den4),
    .div_done(ddone4), .div_quot(quot4), .mean(mean4), .variance(var4));

  always @(posedge clk) begin
    if (rd4) begin
      data4  <= mem4[addr4[1:0]];
      reads4 <= reads4 + 1;
    end
  end

  assign ddone4 = mdone4 | spur4;
  always @(posedge clk) begin
    mdone4 <= 1'b0;
    if (dstart4) begin
      pend4    <= 1'b1;
      cnt4     <= D - 2;
      cap_num4 <= num4;
      cap_den4 <= den4;
      quot4    <= num4 / den4;
      dstarts4 <= dstarts4 + 1;
    end else if (pend4) begin
      if (cnt4 == 0) begin
        mdone4 <= 1'b1;
        pend4  <= 1'b0;
      end else begin
        cnt4 <= cnt4 - 1;
      end
    end
  end

  // ---------------- instance with N_SAMPLES = 1 ----------------
  logic          start1 = 1'b0, busy1, done1, rd1, dstart1, ddone1;
  logic [AW-1:0] addr1, den1;
  logic [DW-1:0] data1, mean1;
  logic [NW-1:0] num1, quot1;
  logic [2*DW-1:0] var1;
  int            reads1 = 0, dstarts1 = 0, cnt1 = 0;
  logic          pend1 = 1'b0, mdone1 = 1'b0;

  snr_stats_sequencer #(.DATA_WIDTH(DW), .N_SAMPLES(1), .ADDR_WIDTH(AW), .NUM_WIDTH(NW)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(rd1), .mem_addr(addr1), .mem_data(data1),
    .div_ready(1'b1), .div_start(dstart1), .div_num(num1), .div_den(den1),
    .div_done(ddone1), .div_quot(quot1), .mean(mean1), .variance(var1));

  always @(posedge clk) begin
    if (rd1) begin
      data1  <= 16'd123;
      reads1 <= reads1 + 1;
    end
  end

  assign ddone1 = mdone1;
  always @(posedge clk) begin
    mdone1 <= 1'b0;
    if (dstart1) begin
      pend1    <= 1'b1;
      cnt1     <= D - 2;
      quot1    <= num1 / den1;
      dstarts1 <= dstarts1 + 1;
    end else if (pend1) begin
      if (cnt1 == 0) begin
        mdone1 <= 1'b1;
        pend1  <= 1'b0;
      end else begin
        cnt1 <= cnt1 - 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  longint exp_mean4 = 0, exp_var4 = 0, held_mean4 = 0, held_var4 = 0;
  longint exp_mean1 = 0, exp_var1 = 0;
  logic   rst_q = 1'b0;

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("reset_mean", mean4, 0);
      chk("reset_variance", var4, 0);
      chk("reset_busy", busy4, 0);
      chk("reset_done", done4, 0);
      chk("reset_rd_en", rd4, 0);
      chk("reset_div_start", dstart4, 0);
      chk("reset_mean1", mean1, 0);
      held_mean4 = 0;
      held_var4  = 0;
    end else begin
      if (done4) begin
        chk("done_mean", mean4, exp_mean4);
        chk("done_variance", var4, exp_var4);
        chk("done_busy_low", busy4, 0);
        held_mean4 = exp_mean4;
        held_var4  = exp_var4;
      end else begin
        chk("hold_mean", mean4, held_mean4);
        chk("hold_variance", var4, held_var4);
      end
      if (rd4) chk("addr_in_range", longint'(addr4 < 4), 1);
      if (dstart4) chk("div_start_needs_ready", ready4, 1);
      if (pend4) begin
        chk("div_num_stable", num4, cap_num4);
        chk("div_den_stable", den4, cap_den4);
      end
      if (done1) begin
        chk("n1_mean", mean1, exp_mean1);
        chk("n1_variance", var1, exp_var1);
      end
    end
  end

  // One block on the N=4 instance: optional divider back-pressure and optional stray start/div_done.
  task automatic run4(input logic [DW-1:0] d0, d1, d2, d3, input int hold, input bit poke);
    longint q[$];
    int k, r0, s0;
    mem4[0] = d0; mem4[1] = d1; mem4[2] = d2; mem4[3] = d3;
    q = {};
    q.push_back(d0); q.push_back(d1); q.push_back(d2); q.push_back(d3);
    stats(q, exp_mean4, exp_var4);
    r0 = reads4;
    s0 = dstarts4;
    start4 = 1'b1;
    if (hold > 0) ready4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    k = 1;
    chk("busy_after_start", busy4, 1);
    while (!done4 && k < 400) begin
      spur4  = poke && (k == 2);
      start4 = poke && (k == 5);
      if (k == 6 + hold) ready4 = 1'b1;
      @(negedge clk);
      k++;
    end
    spur4 = 1'b0;
    start4 = 1'b0;
    ready4 = 1'b1;
    chk("done_seen", done4, 1);
    chk("latency", k, 20 + hold);
    chk("read_count", reads4 - r0, 8);
    chk("div_start_count", dstarts4 - s0, 2);
    @(negedge clk);
    chk("no_restart_after_done", busy4, 0);
  endtask

  initial begin
    longint pm, pv;
    longint pq[$];
    int k, s0, r0;
    logic [DW-1:0] a, b, c, d;

    pq = {};
    pq.push_back(2); pq.push_back(4); pq.push_back(6); pq.push_back(8);
    stats(pq, pm, pv);
    chk("model_pin_mean", pm, 5);
    chk("model_pin_variance", pv, 6);
    pq = {};
    pq.push_back(1); pq.push_back(1); pq.push_back(1); pq.push_back(3);
    stats(pq, pm, pv);
    chk("model_pin_mean_b", pm, 1);
    chk("model_pin_variance_b", pv, 1);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run4(16'd2, 16'd4, 16'd6, 16'd8, 0, 1'b0);
    chk("basic_mean_literal", mean4, 5);
    chk("basic_variance_literal", var4, 6);
    run4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    chk("full_scale_mean_literal", mean4, 65535);
    run4(16'd2, 16'd4, 16'd6, 16'd8, 10, 1'b0);
    run4(16'd2, 16'd4, 16'd6, 16'd8, 0, 1'b1);

    // N=1 block: the variance divide must be skipped.
    exp_mean1 = 123;
    exp_var1  = 0;
    s0 = dstarts1;
    r0 = reads1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 1;
    while (!done1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("n1_done_seen", done1, 1);
    chk("n1_latency", k, 10);
    chk("n1_div_starts", dstarts1 - s0, 1);
    chk("n1_reads", reads1 - r0, 2);

    // Abort mid squared-deviation pass, with start colliding with reset.
    mem4[0] = 16'd2; mem4[1] = 16'd4; mem4[2] = 16'd6; mem4[3] = 16'd8;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    while (!ddone4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_mean_div_done_seen", ddone4, 1);
    repeat (3) @(negedge clk);
    chk("abort_in_sq_pass", rd4, 1);
    reset = 1'b1;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start4 = 1'b0;
    @(negedge clk);
    chk("start_with_reset_ignored", busy4, 0);
    spur4 = 1'b1;
    @(negedge clk);
    spur4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_div_done_idle", busy4, 0);
    chk("post_reset_mean", mean4, 0);
    run4(16'd1, 16'd1, 16'd1, 16'd3, 0, 1'b0);
    chk("after_abort_mean_literal", mean4, 1);
    chk("after_abort_variance_literal", var4, 1);

    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = (i % 3 == 0) ? 16'hFFFF : 16'($urandom);
      d = (i % 4 == 0) ? 16'h0000 : 16'($urandom);
      run4(a, b, c, d, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
